// File: rtl/noisy_channel_pkg.sv
// Shared encodings and constants for the noisy channel and its LFSR.
package noisy_channel_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_ALT    = 2'd1,
    MODE_PERIOD = 2'd2,
    MODE_RAND   = 2'd3
  } mode_e;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Taps at bits 0,2,3,5: x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/noisy_channel_if.sv
// Valid/ready stream, run-time policy and statistics of the noisy channel.
interface noisy_channel_if #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 16
);
  import noisy_channel_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] din;
  mode_e             mode;
  logic [7:0]        period;
  logic [7:0]        threshold;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] dout;
  logic              out_corrupt;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output in_valid, din, mode, period, threshold, out_ready,
    input  in_ready, out_valid, dout, out_corrupt, word_cnt, err_cnt
  );

  modport slave (
    input  in_valid, din, mode, period, threshold, out_ready,
    output in_ready, out_valid, dout, out_corrupt, word_cnt, err_cnt
  );

endinterface

// File: rtl/noisy_channel_lfsr_gen.sv
// Fibonacci LFSR stepping once per enable; a zero seed is forced to 1 to avoid lock-up.
module lfsr_gen
  import noisy_channel_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(LFSR_TAPS);
  localparam logic [LFSR_W-1:0] RST_VAL = (SEED == {LFSR_W{1'b0}}) ?
                                          {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] r_state;
  logic              w_fb;

  assign w_fb  = ^(r_state & TAPS);
  assign state = r_state;

  // LFSR state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RST_VAL;
    end else if (en) begin
      r_state <= {w_fb, r_state[LFSR_W-1:1]};
    end else begin
      r_state <= r_state;
    end
  end

endmodule

// File: rtl/noisy_channel.sv
// One-word pipelined channel that overwrites the low bits of selected words with LFSR noise.
module noisy_channel
  import noisy_channel_pkg::*;
#(
  parameter int                DATA_W = 10,
  parameter int                KEEP_W = 3,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  noisy_channel_if.slave   bus
);

  localparam logic [DATA_W-1:0] LOW_MASK = {DATA_W{1'b1}} >> KEEP_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [LFSR_W-1:0] w_lfsr;
  logic              w_in_ready;
  logic              w_accept;
  logic [7:0]        w_per_last;
  logic              w_per_hit;
  logic              w_corrupt;
  logic [DATA_W-1:0] w_noisy;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_dout;
  logic              r_out_corrupt;
  logic              r_alt_toggle;
  logic [7:0]        r_per_cnt;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0]  r_err_cnt;

  lfsr_gen #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (w_accept),
    .state (w_lfsr)
  );

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  // ">=" rather than "==" so a shrinking period fires on the next word instead of waiting for wrap
  assign w_per_last = (bus.period == 8'd0) ? 8'd0 : bus.period - 8'd1;
  assign w_per_hit  = (r_per_cnt >= w_per_last);
  assign w_noisy    = (bus.din & ~LOW_MASK) | (DATA_W'(w_lfsr) & LOW_MASK);

  // Corruption decision from pre-edge policy state
  always_comb begin
    w_corrupt = 1'b0;
    case (bus.mode)
      MODE_PASS:   w_corrupt = 1'b0;
      MODE_ALT:    w_corrupt = r_alt_toggle;
      MODE_PERIOD: w_corrupt = w_per_hit;
      MODE_RAND:   w_corrupt = (w_lfsr[7:0] < bus.threshold);
      default:     w_corrupt = 1'b0;
    endcase
  end

  // Output register: load on accept, empty on drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_dout        <= {DATA_W{1'b0}};
      r_out_corrupt <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_dout        <= w_corrupt ? w_noisy : bus.din;
      r_out_corrupt <= w_corrupt;
    end else if (bus.out_ready) begin
      r_out_valid   <= 1'b0;
    end else begin
      r_out_valid   <= r_out_valid;
    end
  end

  // Policy state advances on every accepted word whatever the current mode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alt_toggle <= 1'b0;
      r_per_cnt    <= 8'd0;
    end else if (w_accept) begin
      r_alt_toggle <= ~r_alt_toggle;
      r_per_cnt    <= w_per_hit ? 8'd0 : r_per_cnt + 8'd1;
    end else begin
      r_alt_toggle <= r_alt_toggle;
    end
  end

  // Saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= {CNT_W{1'b0}};
      r_err_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_accept && (r_word_cnt != CNT_MAX)) begin
        r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_accept && w_corrupt && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.dout        = r_dout;
  assign bus.out_corrupt = r_out_corrupt;
  assign bus.word_cnt    = r_word_cnt;
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_noisy_channel.sv
// Scoreboard bench for noisy_channel: a reference model predicts each accepted word.
module tb_noisy_channel;
  import noisy_channel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noisy_channel_if #(.DATA_W(10), .CNT_W(16)) bus ();

  noisy_channel #(
    .DATA_W(10), .KEEP_W(3), .LFSR_W(16), .SEED(16'hACE1), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int exp_rd = 0;
  int obs_rd = 0;

  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_alt  = 1'b0;
  logic [7:0]  m_per  = 8'd0;
  logic        m_ov   = 1'b0;
  logic [15:0] m_word = 16'd0;
  logic [15:0] m_err  = 16'd0;

  // Reference model: inputs are stable at the falling edge, so predict what the next edge does
  always @(negedge clk) begin : model
    logic       acc;
    logic       cor;
    logic [7:0] plast;
    logic [9:0] w;
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_alt  <= 1'b0;
      m_per  <= 8'd0;
      m_ov   <= 1'b0;
      m_word <= 16'd0;
      m_err  <= 16'd0;
    end else begin
      if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_corrupt, bus.dout});
      acc   = bus.in_valid && (!m_ov || bus.out_ready);
      plast = (bus.period == 8'd0) ? 8'd0 : bus.period - 8'd1;
      case (bus.mode)
        MODE_PASS:   cor = 1'b0;
        MODE_ALT:    cor = m_alt;
        MODE_PERIOD: cor = (m_per >= plast);
        default:     cor = (m_lfsr[7:0] < bus.threshold);
      endcase
      w = cor ? {bus.din[9:7], m_lfsr[6:0]} : bus.din;
      if (acc) begin
        exp_q.push_back({cor, w});
        m_per  <= (m_per >= plast) ? 8'd0 : m_per + 8'd1;
        m_alt  <= ~m_alt;
        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        m_ov   <= 1'b1;
        if (m_word != 16'hFFFF) m_word <= m_word + 16'd1;
        if (cor && m_err != 16'hFFFF) m_err <= m_err + 16'd1;
      end else if (bus.out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_rd = exp_q.size();
    obs_rd = obs_q.size();
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    do_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.dout !== 10'h000 || bus.out_corrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out got valid=%b dout=%h cor=%b want 0/000/0", bus.out_valid, bus.dout, bus.out_corrupt);
    end
    n_checks++;
    if (bus.word_cnt !== 16'd0 || bus.err_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cnt got word=%0d err=%0d rdy=%b want 0/0/1", bus.word_cnt, bus.err_cnt, bus.in_ready);
    end
  endtask

  task automatic test_pass();
    do_reset();
    bus.mode = MODE_PASS;
    bus.din = 10'h155;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.dout !== 10'h155 || bus.out_corrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_word got valid=%b dout=%h cor=%b want 1/155/0", bus.out_valid, bus.dout, bus.out_corrupt);
    end
    n_checks++;
    if (bus.word_cnt !== 16'd1 || bus.err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL pass_cnt got word=%0d err=%0d want 1/0", bus.word_cnt, bus.err_cnt);
    end
    tick();
    while (obs_rd < obs_q.size()) begin
      n_checks++;
      if (exp_rd >= exp_q.size() || obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++;
        $display("FAIL sb_pass got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      obs_rd++;
      exp_rd++;
    end
  endtask

  task automatic test_alt(input string tag);
    bus.mode = MODE_ALT;
    bus.din = 10'h3FF;
    bus.in_valid = 1'b1;
    tick();
    n_checks++;
    if (bus.dout !== 10'h3FF || bus.out_corrupt !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_first got dout=%h cor=%b want 3ff/0", tag, bus.dout, bus.out_corrupt);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.dout !== 10'h3F0 || bus.out_corrupt !== 1'b1 || bus.err_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL %s_second got dout=%h cor=%b err=%0d want 3f0/1/1", tag, bus.dout, bus.out_corrupt, bus.err_cnt);
    end
    tick();
    while (obs_rd < obs_q.size()) begin
      n_checks++;
      if (exp_rd >= exp_q.size() || obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++;
        $display("FAIL sb_%s got %h want %h", tag, obs_q[obs_rd], exp_q[exp_rd]);
      end
      obs_rd++;
      exp_rd++;
    end
  endtask

  task automatic test_period(input logic [7:0] per, input int exp_err);
    do_reset();
    bus.mode = MODE_PERIOD;
    bus.period = per;
    for (int i = 0; i < 12; i++) begin
      bus.din = 10'($urandom);
      bus.in_valid = 1'b1;
      tick();
      n_checks++;
      if (bus.out_corrupt !== ((per == 8'd0 || (i % 4) == 3) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL period%0d_word%0d got cor=%b", per, i + 1, bus.out_corrupt);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.err_cnt !== 16'(exp_err) || bus.word_cnt !== 16'd12) begin
      n_fail++;
      $display("FAIL period%0d_cnt got err=%0d word=%0d want %0d/12", per, bus.err_cnt, bus.word_cnt, exp_err);
    end
    while (obs_rd < obs_q.size()) begin
      n_checks++;
      if (exp_rd >= exp_q.size() || obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++;
        $display("FAIL sb_period got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      obs_rd++;
      exp_rd++;
    end
  endtask

  task automatic test_random(input logic [7:0] thr);
    do_reset();
    bus.mode = MODE_RAND;
    bus.threshold = thr;
    for (int i = 0; i < 1000; i++) begin
      bus.din = 10'($urandom);
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.err_cnt !== m_err || bus.word_cnt !== 16'd1000) begin
      n_fail++;
      $display("FAIL rand%0d_cnt got err=%0d word=%0d want %0d/1000", thr, bus.err_cnt, bus.word_cnt, m_err);
    end
    n_checks++;
    if ((thr == 8'd0 && bus.err_cnt !== 16'd0) ||
        (thr == 8'd255 && (bus.err_cnt < 16'd990 || bus.err_cnt > 16'd1000))) begin
      n_fail++;
      $display("FAIL rand%0d_range got err=%0d", thr, bus.err_cnt);
    end
    while (obs_rd < obs_q.size()) begin
      n_checks++;
      if (exp_rd >= exp_q.size() || obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++;
        $display("FAIL sb_rand got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      obs_rd++;
      exp_rd++;
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] held;
    int start;
    do_reset();
    start = obs_q.size();
    bus.mode = MODE_RAND;
    bus.threshold = 8'd128;
    bus.out_ready = 1'b0;
    bus.din = 10'h2A5;
    bus.in_valid = 1'b1;
    tick();
    held = exp_q[exp_q.size() - 1];
    bus.din = 10'h15A;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || {bus.out_corrupt, bus.dout} !== held || bus.word_cnt !== 16'd1) begin
        n_fail++;
        $display("FAIL bp_hold%0d got rdy=%b dout=%h word=%0d want 0/%h/1", i, bus.in_ready, {bus.out_corrupt, bus.dout}, bus.word_cnt, held);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.din = 10'h0F0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.word_cnt !== 16'd3 || obs_q.size() - start != 3) begin
      n_fail++;
      $display("FAIL bp_count got word=%0d delivered=%0d want 3/3", bus.word_cnt, obs_q.size() - start);
    end
    while (obs_rd < obs_q.size()) begin
      n_checks++;
      if (exp_rd >= exp_q.size() || obs_q[obs_rd] !== exp_q[exp_rd]) begin
        n_fail++;
        $display("FAIL sb_bp got %h want %h", obs_q[obs_rd], exp_q[exp_rd]);
      end
      obs_rd++;
      exp_rd++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mode = MODE_ALT;
    bus.out_ready = 1'b0;
    bus.din = 10'h3FF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_held got valid=%b want 1", bus.out_valid);
    end
    do_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.word_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset got valid=%b word=%0d err=%0d want 0/0/0", bus.out_valid, bus.word_cnt, bus.err_cnt);
    end
    bus.out_ready = 1'b1;
    test_alt("mid");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.din       = 10'h000;
    bus.mode      = MODE_PASS;
    bus.period    = 8'd4;
    bus.threshold = 8'd0;
    bus.out_ready = 1'b1;
    tick();
    test_reset();
    test_pass();
    do_reset();
    test_alt("alt");
    test_period(8'd4, 3);
    test_period(8'd0, 12);
    test_random(8'd0);
    test_random(8'd255);
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
